// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitration controller.
// MAX_W bounds the widest requester vector the helpers can handle.
package rr_arb_pkg;

    localparam int unsigned MAX_W = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Keeps bits whose index is in [ptr, w).
    function automatic logic [MAX_W-1:0] thermo_mask(input int unsigned ptr, input int unsigned w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            m[i] = (i >= ptr) && (i < w);
        end
        return m;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arb_ctrl_if #(
    parameter int unsigned W    = 256,
    parameter int unsigned IDXW = $clog2(W)
);
    logic [W-1:0]    Req;
    logic            ack;
    logic            ptr_load;
    logic [IDXW-1:0] ptr_val;
    logic [W-1:0]    Gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            valid;
    logic            tmo_err;

    modport master (
        output Req, ack, ptr_load, ptr_val,
        input  Gnt, gnt_idx, valid, tmo_err
    );

    modport slave (
        input  Req, ack, ptr_load, ptr_val,
        output Gnt, gnt_idx, valid, tmo_err
    );
endinterface

// File: rtl/rr_pe_lsb.sv
// Lowest-index-first one-hot priority encoder with an any-request flag.
module rr_pe_lsb #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_gnt,
    output logic         o_any
);
    // Two's-complement trick isolates the lowest set bit.
    assign o_gnt = i_req & (~i_req + 1'b1);
    assign o_any = |i_req;
endmodule

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter: rotating-pointer masked/raw priority encoders feed a
// registered one-hot grant held until ack or watchdog expiry.
//
// state | meaning
// IDLE  | no owner; arbitrate Req every cycle, ptr_load honoured
// BUSY  | grant frozen for the owner until ack or watchdog expiry
module rr_arb_ctrl
    import rr_arb_pkg::*;
#(
    parameter int unsigned W    = 256,
    parameter int unsigned IDXW = $clog2(W),
    parameter int unsigned TMO  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_ctrl_if.slave  bus
);
    localparam int unsigned     WDW      = (TMO == 0) ? 1 : $clog2(TMO + 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(W - 1);
    localparam logic [IDXW:0]   W_LIM    = (IDXW + 1)'(W);
    localparam logic [WDW-1:0]  WD_LAST  = WDW'((TMO == 0) ? 0 : TMO - 1);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_gnt_idx;
    logic [W-1:0]    r_gnt;
    logic [WDW-1:0]  r_wdog;
    logic            r_valid;
    logic            r_tmo_err;

    logic [W-1:0]    w_mask;
    logic [W-1:0]    w_masked;
    logic [W-1:0]    w_pe_m_gnt;
    logic [W-1:0]    w_pe_r_gnt;
    logic [W-1:0]    w_win;
    logic            w_pe_m_any;
    logic            w_pe_r_any;
    logic [IDXW-1:0] w_win_idx;
    logic [IDXW-1:0] w_ptr_clamp;
    logic [IDXW-1:0] w_ptr_next;
    logic            w_wdog_exp;

    always_comb begin
        w_mask    = W'(thermo_mask(32'(r_ptr), W));
        w_win_idx = IDXW'(onehot_to_idx(MAX_W'(w_win)));
    end

    assign w_masked = bus.Req & w_mask;

    rr_pe_lsb #(.W(W)) u_pe_masked (
        .i_req (w_masked),
        .o_gnt (w_pe_m_gnt),
        .o_any (w_pe_m_any)
    );

    rr_pe_lsb #(.W(W)) u_pe_raw (
        .i_req (bus.Req),
        .o_gnt (w_pe_r_gnt),
        .o_any (w_pe_r_any)
    );

    // Fall back to the raw encoder when nothing at or above ptr is requesting.
    assign w_win       = w_pe_m_any ? w_pe_m_gnt : w_pe_r_gnt;
    assign w_ptr_clamp = ({1'b0, bus.ptr_val} >= W_LIM) ? '0 : bus.ptr_val;
    assign w_ptr_next  = (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + 1'b1;
    assign w_wdog_exp  = (TMO != 0) && (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_wdog    <= '0;
            r_valid   <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.ptr_load) r_ptr <= w_ptr_clamp;
                    if (w_pe_r_any) begin
                        r_gnt     <= w_win;
                        r_gnt_idx <= w_win_idx;
                        r_wdog    <= '0;
                        r_valid   <= 1'b1;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    // ack takes precedence over a simultaneous expiry.
                    if (bus.ack || w_wdog_exp) begin
                        r_ptr     <= w_ptr_next;
                        r_gnt     <= '0;
                        r_gnt_idx <= '0;
                        r_valid   <= 1'b0;
                        r_tmo_err <= !bus.ack;
                        r_state   <= IDLE;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.Gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.valid   = r_valid;
    assign bus.tmo_err = r_tmo_err;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Scoreboard bench for rr_arb_ctrl: stimulus queues expected grants/timeouts,
// a negedge monitor pops and compares them as the DUTs present outputs.
module tb_rr_arb_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst256_n = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rr_arb_ctrl_if #(.W(8),   .IDXW(3)) b8();
    rr_arb_ctrl_if #(.W(10),  .IDXW(4)) b10();
    rr_arb_ctrl_if #(.W(256), .IDXW(8)) b256();

    rr_arb_ctrl #(.W(8),   .IDXW(3), .TMO(4))    u8   (.clk(clk), .rst_n(rst_n),    .bus(b8));
    rr_arb_ctrl #(.W(10),  .IDXW(4), .TMO(0))    u10  (.clk(clk), .rst_n(rst_n),    .bus(b10));
    rr_arb_ctrl #(.W(256), .IDXW(8), .TMO(1024)) u256 (.clk(clk), .rst_n(rst256_n), .bus(b256));

    typedef struct {
        int id;
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic pv8 = 1'b0, pv10 = 1'b0, pv256 = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input int idx, input int c);
        exp_t e;
        e.id  = id;
        e.idx = idx;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic mon_one(input int id, input logic v, input logic [255:0] g, input int idx, input logic pv);
        exp_t e;
        logic [255:0] oh;
        oh = 256'd1;
        oh = oh << idx;
        if (v) begin
            chk("gnt_onehot_matches_idx", g, oh);
        end else begin
            chk("gnt_zero_when_idle", g, '0);
            chk("idx_zero_when_idle", idx, 0);
        end
        if (v && !pv) begin
            chk("grant_was_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant_dut", id, e.id);
                chk("grant_idx", idx, e.idx);
                chk("grant_cycle", cyc, e.cyc);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_one(0, b8.valid,   256'(b8.Gnt),   int'(b8.gnt_idx),   pv8);
            mon_one(1, b10.valid,  256'(b10.Gnt),  int'(b10.gnt_idx),  pv10);
            mon_one(2, b256.valid, 256'(b256.Gnt), int'(b256.gnt_idx), pv256);
            pv8   = b8.valid;
            pv10  = b10.valid;
            pv256 = b256.valid;
            if (b8.tmo_err) begin
                chk("tmo_was_expected", tq.size() > 0, 1'b1);
                if (tq.size() > 0) chk("tmo_cycle", cyc, tq.pop_front());
            end
            chk("tmo10_disabled", b10.tmo_err, 1'b0);
            chk("tmo256_quiet", b256.tmo_err, 1'b0);
        end
    end

    task automatic drv(input int id, input logic [255:0] req, input logic ack, input logic ld, input int val);
        case (id)
            0: begin
                b8.Req = req[7:0]; b8.ack = ack; b8.ptr_load = ld; b8.ptr_val = val[2:0];
            end
            1: begin
                b10.Req = req[9:0]; b10.ack = ack; b10.ptr_load = ld; b10.ptr_val = val[3:0];
            end
            default: begin
                b256.Req = req; b256.ack = ack; b256.ptr_load = ld; b256.ptr_val = val[7:0];
            end
        endcase
    endtask

    // Request in IDLE, expect grant one edge later; optionally ack the next cycle.
    task automatic g(input int id, input logic [255:0] req, input int exp_idx, input bit do_ack);
        drv(id, req, 1'b0, 1'b0, 0);
        push_exp(id, exp_idx, cyc + 1);
        @(negedge clk);
        if (do_ack) begin
            drv(id, req, 1'b1, 1'b0, 0);
            @(negedge clk);
            drv(id, '0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic ld(input int id, input int val);
        drv(id, '0, 1'b0, 1'b1, val);
        @(negedge clk);
        drv(id, '0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic [255:0] r;
        drv(0, '0, 1'b0, 1'b0, 0);
        drv(1, '0, 1'b0, 1'b0, 0);
        drv(2, '0, 1'b0, 1'b0, 0);
        #1;
        rst_n    = 1'b0;
        rst256_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt", b8.Gnt, '0);
        chk("rst_idx", b8.gnt_idx, '0);
        chk("rst_valid", b8.valid, 1'b0);
        chk("rst_tmo", b8.tmo_err, 1'b0);
        chk("rst256_valid", b256.valid, 1'b0);
        rst_n    = 1'b1;
        rst256_n = 1'b1;
        @(negedge clk);

        // Rotation from ptr=0 over 1010_0100
        g(0, 8'hA4, 2, 1);
        g(0, 8'hA4, 5, 1);
        g(0, 8'hA4, 7, 1);
        g(0, 8'hA4, 2, 1);

        // Empty masked set falls back to the lowest raw request
        ld(0, 6);
        g(0, 8'h03, 0, 1);
        g(0, 8'h03, 1, 1);

        // All requesting continuously: 0..7 then wrap to 0
        ld(0, 0);
        for (int i = 0; i < 8; i++) g(0, 8'hFF, i, 1);
        g(0, 8'hFF, 0, 1);

        // Watchdog expiry, with Req withdrawn during BUSY
        ld(0, 3);
        drv(0, 8'h08, 1'b0, 1'b0, 0);
        push_exp(0, 3, cyc + 1);
        tq.push_back(cyc + 1 + 4);
        @(negedge clk);
        drv(0, '0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("wdog_hold_valid", b8.valid, 1'b1);
        @(negedge clk);
        chk("wdog_revoke_valid", b8.valid, 1'b0);
        chk("wdog_revoke_gnt", b8.Gnt, '0);
        g(0, 8'h18, 4, 1);

        // ack on the expiry cycle wins over the watchdog
        ld(0, 3);
        drv(0, 8'h08, 1'b0, 1'b0, 0);
        push_exp(0, 3, cyc + 1);
        @(negedge clk);
        drv(0, '0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        drv(0, '0, 1'b1, 1'b0, 0);
        @(negedge clk);
        drv(0, '0, 1'b0, 1'b0, 0);
        chk("ack_wins_no_tmo", b8.tmo_err, 1'b0);
        chk("ack_wins_valid", b8.valid, 1'b0);
        g(0, 8'h18, 4, 1);

        // Pointer load in IDLE; load in BUSY ignored; same-cycle load uses old ptr
        ld(0, 5);
        drv(0, 8'hFF, 1'b0, 1'b0, 0);
        push_exp(0, 5, cyc + 1);
        @(negedge clk);
        drv(0, 8'hFF, 1'b0, 1'b1, 1);
        @(negedge clk);
        drv(0, 8'hFF, 1'b1, 1'b0, 0);
        @(negedge clk);
        drv(0, '0, 1'b0, 1'b0, 0);
        g(0, 8'hFF, 6, 1);
        drv(0, 8'hFF, 1'b0, 1'b1, 2);
        push_exp(0, 7, cyc + 1);
        @(negedge clk);
        drv(0, 8'hFF, 1'b1, 1'b0, 0);
        @(negedge clk);
        drv(0, '0, 1'b0, 1'b0, 0);
        g(0, 8'hFF, 0, 1);

        // W=10, watchdog disabled, out-of-range pointer clamps to 0
        ld(1, 7);
        g(1, 10'h081, 7, 0);
        repeat (20) @(negedge clk);
        chk("tmo_off_still_busy", b10.valid, 1'b1);
        drv(1, '0, 1'b1, 1'b0, 0);
        @(negedge clk);
        drv(1, '0, 1'b0, 1'b0, 0);
        g(1, 10'h081, 0, 1);
        ld(1, 12);
        g(1, 10'h300, 8, 1);

        // W=256: async reset mid-grant, pointer returns to 0
        r = '0;
        r[5] = 1'b1;
        g(2, r, 5, 1);
        r = '0;
        r[255] = 1'b1;
        drv(2, r, 1'b0, 1'b0, 0);
        push_exp(2, 255, cyc + 1);
        @(negedge clk);
        #2;
        rst256_n = 1'b0;
        #1;
        chk("async_rst_valid", b256.valid, 1'b0);
        chk("async_rst_gnt", b256.Gnt, '0);
        @(negedge clk);
        rst256_n = 1'b1;
        r[0] = 1'b1;
        g(2, r, 0, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("tmo_drained", tq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
